alu_mc_sequencer: RTL and testbench
===================================

// Module: alu_mc_sequencer
// PURPOSE
//  Upstream issue/collect stage for the ALU's multi-cycle units (multiplier, divider, modulo).
//  - Accepts one operation from the control unit over a valid/ready handshake.
//  - Holds the operands stable and pulses the selected unit's start.
//  - Waits for that unit's done, with a timeout guard.
//  - Registers result and flags {Z,N,C,V} and presents them on a valid/ready response port until consumed.
// PARAMETERS
//  WIDTH        16  operand/result width
//  TIMEOUT_CYC  40  max cycles in WAIT before the op is aborted
//  CNT_W        6   width of the wait counter; must satisfy 2**CNT_W > TIMEOUT_CYC
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         reset, asynchronous, active-high
//  req_valid  in   1         request present
//  req_ready  out  1         sequencer can accept; equals (state==IDLE)
//  req_op     in   2         00 mul, 01 div, 10 mod, 11 reserved
//  req_a      in   WIDTH     operand A
//  req_b      in   WIDTH     operand B
//  unit_a     out  WIDTH     registered operand A to all units
//  unit_b     out  WIDTH     registered operand B to all units
//  unit_start out  3         one-hot start pulse: [0] mul, [1] div, [2] mod
//  unit_done  in   3         per-unit done: [0] mul, [1] div, [2] mod
//  unit_res   in   3*WIDTH   {mod,div,mul} results
//  unit_flg   in   12        {mod,div,mul} flags, 4 bits each, order {Z,N,C,V}
//  rsp_valid  out  1         response held
//  rsp_ready  in   1         consumer accepts response
//  rsp_result out  WIDTH     captured result
//  rsp_flags  out  4         captured {Z,N,C,V}
//  rsp_err    out  1         1 = timeout or reserved op
//  busy       out  1         state != IDLE
// BEHAVIOUR
//  Reset
//  - Async; state=IDLE, unit_start=0, rsp_valid=0, rsp_err=0.
//  - rsp_result, rsp_flags, unit_a, unit_b, counter all 0; req_ready=1 while rst is low.
//  - Reset mid-operation drops the pending op; unit_start falls immediately.
//  FSM: IDLE -> LAUNCH -> WAIT -> RESP -> IDLE
//  - IDLE: on req_valid&&req_ready, register op/a/b into unit_a/unit_b.
//    Next state: LAUNCH, or RESP if op==11.
//  - Reserved op: capture result=0, flags=4'b0001, err=1.
//  - LAUNCH: exactly one cycle. unit_start[op]=1, all other bits 0. Counter cleared.
//    unit_done is ignored in this cycle (stale done from a prior op).
//  - WAIT: counter increments each cycle. If unit_done[op]=1, capture the unit's result
//    slice and flag slice, err=0, go to RESP.
//  - WAIT, done bits of non-selected units are ignored.
//  - WAIT timeout: if the counter reaches TIMEOUT_CYC without done, capture result=0,
//    flags=4'b0001, err=1, go to RESP.
//  - WAIT, done and timeout in the same cycle: done wins.
//  - RESP: rsp_valid=1. rsp_result/flags/err stay stable until the rsp_valid&&rsp_ready cycle.
//    Then go to IDLE; rsp_valid drops next cycle.
//  - RESP, no new request is accepted (req_ready=0), so at most one op is in flight.
//  - Operands: unit_a/unit_b change only on acceptance, stable through LAUNCH/WAIT/RESP.
//  - Latency, accept edge to rsp_valid: reserved op = 1 cycle; unit op = 2 + (cycles from
//    start to done).
//  - Width: results pass through unmodified; no sign handling here (done by the units).
// TESTING
//  1. Mod -7 % 3 (a=16'hFFF9, b=3); unit model sets done[2] 17 cycles after start with
//     res=16'hFFFF, flg=0100 -> one start[2] pulse; rsp_result=16'hFFFF, rsp_flags=0100,
//     rsp_err=0.
//  2. Div with done never asserted -> after TIMEOUT_CYC WAIT cycles: rsp_valid=1,
//     rsp_result=0, rsp_flags=0001, rsp_err=1; next request accepted after rsp_ready.
//  3. req_op=11 -> no unit_start; rsp_valid the cycle after acceptance with rsp_err=1,
//     flags=0001.
//  4. Mod requested while done[1] held high throughout -> ignored; response waits for
//     done[2].
//  5. rsp_ready low for 10 cycles in RESP -> rsp_* stable, req_ready=0, req_valid ignored.
//     Then rsp_ready=1 -> IDLE next cycle.
//  6. Assert rst 5 cycles into WAIT -> unit_start=0, rsp_valid=0, busy=0 immediately.
//     A fresh mul after release completes normally.

Source files
------------

// File: rtl/alu_mc_sequencer.sv
// Issue/collect sequencer for the ALU's multi-cycle units (mul, div, mod).
// Accepts one op, launches the selected unit, waits for its done (with a
// timeout guard) and holds the captured result until the consumer takes it.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | ready for a new request
// LAUNCH  | one-cycle start pulse to the selected unit, counter cleared
// WAIT    | waiting for the selected unit's done, counting towards timeout
// RESP    | response held on the rsp_* port until rsp_ready
module alu_mc_sequencer #(
    parameter int WIDTH       = 16,
    parameter int TIMEOUT_CYC = 40,
    parameter int CNT_W       = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]   unit_a,
    output logic [WIDTH-1:0]   unit_b,
    output logic [2:0]         unit_start,
    input  logic [2:0]         unit_done,
    input  logic [3*WIDTH-1:0] unit_res,
    input  logic [11:0]        unit_flg,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_result,
    output logic [3:0]         rsp_flags,
    output logic               rsp_err,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [1:0] OP_RSVD   = 2'b11;
    localparam logic [3:0] FLG_ABORT = 4'b0001;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [3:0]         flg_q, flg_d;
    logic               err_q, err_d;

    logic               sel_done;
    logic [WIDTH-1:0]   sel_res;
    logic [3:0]         sel_flg;
    logic               timeout;

    // Pick the done/result/flag slice of the unit that owns the current op.
    always_comb begin
        sel_done = 1'b0;
        sel_res  = '0;
        sel_flg  = '0;
        case (op_q)
            2'b00: begin
                sel_done = unit_done[0];
                sel_res  = unit_res[0*WIDTH +: WIDTH];
                sel_flg  = unit_flg[3:0];
            end
            2'b01: begin
                sel_done = unit_done[1];
                sel_res  = unit_res[1*WIDTH +: WIDTH];
                sel_flg  = unit_flg[7:4];
            end
            2'b10: begin
                sel_done = unit_done[2];
                sel_res  = unit_res[2*WIDTH +: WIDTH];
                sel_flg  = unit_flg[11:8];
            end
            default: begin
                sel_done = 1'b0;
                sel_res  = '0;
                sel_flg  = '0;
            end
        endcase
    end

    // The counter holds the number of WAIT cycles already spent, so the
    // last permitted WAIT cycle is the one where it reads TIMEOUT_CYC-1.
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Next-state and capture logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        flg_d   = flg_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d = req_op;
                    a_d  = req_a;
                    b_d  = req_b;
                    if (req_op == OP_RSVD) begin
                        res_d   = '0;
                        flg_d   = FLG_ABORT;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                // A done still high from the previous op is not looked at here.
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (sel_done) begin
                    res_d   = sel_res;
                    flg_d   = sel_flg;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (timeout) begin
                    res_d   = '0;
                    flg_d   = FLG_ABORT;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            flg_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            err_q   <= err_d;
        end
    end

    // Start pulse decoded from the state register so a reset drops it at once.
    always_comb begin
        unit_start = 3'b000;
        if (state_q == S_LAUNCH) begin
            case (op_q)
                2'b00:   unit_start = 3'b001;
                2'b01:   unit_start = 3'b010;
                2'b10:   unit_start = 3'b100;
                default: unit_start = 3'b000;
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign rsp_valid  = (state_q == S_RESP);
    assign unit_a     = a_q;
    assign unit_b     = b_q;
    assign rsp_result = res_q;
    assign rsp_flags  = flg_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_mc_sequencer.sv
// Self-checking bench for alu_mc_sequencer: a behavioural unit model drives
// done/result per op and a reference model predicts latency and response.
module tb_alu_mc_sequencer;

    localparam int W = 16;
    localparam int T = 40;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;
    logic [W-1:0]  unit_a;
    logic [W-1:0]  unit_b;
    logic [2:0]    unit_start;
    logic [2:0]    unit_done;
    logic [3*W-1:0] unit_res;
    logic [11:0]   unit_flg;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_result;
    logic [3:0]    rsp_flags;
    logic          rsp_err;
    logic          busy;

    int errors = 0;
    int checks = 0;

    alu_mc_sequencer #(.WIDTH(W), .TIMEOUT_CYC(T), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .unit_a     (unit_a),
        .unit_b     (unit_b),
        .unit_start (unit_start),
        .unit_done  (unit_done),
        .unit_res   (unit_res),
        .unit_flg   (unit_flg),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One complete transaction. d = WAIT cycle (1-based) in which the unit
    // raises done; outside 1..T the op must time out. noise: 0 other dones
    // low, 1 random, 2 held high. hold = cycles rsp_ready stays low.
    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input int d, input int noise, input int hold,
                          input bit req_in_hold);
        logic [W-1:0] e_res;
        logic [3:0]   e_flg;
        logic         e_err;
        int           e_lat;
        int           e_starts;
        logic [2:0]   sel_oh;
        logic [2:0]   dn;
        int           cyc;
        int           seen;
        int           starts;

        if (op == 2'b11) begin
            e_res = '0; e_flg = 4'b0001; e_err = 1'b1; e_lat = 1; sel_oh = 3'b000;
        end else begin
            sel_oh = 3'b001 << op;
            if (d >= 1 && d <= T) begin
                e_res = unit_res[op*W +: W];
                e_flg = unit_flg[op*4 +: 4];
                e_err = 1'b0;
                e_lat = d + 2;
            end else begin
                e_res = '0; e_flg = 4'b0001; e_err = 1'b1; e_lat = T + 2;
            end
        end
        e_starts = (op == 2'b11) ? 0 : 1;

        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept_ready: got %b want 1", name, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a = W'($urandom);
        req_b = W'($urandom);
        checks++;
        if (unit_a !== a || unit_b !== b) begin
            errors++;
            $display("FAIL %s operands: got %h/%h want %h/%h", name, unit_a, unit_b, a, b);
        end

        cyc = 1; seen = 0; starts = 0;
        while (cyc <= T + 10 && seen == 0) begin
            if (unit_start != 3'b000) starts++;
            if (cyc == 1) begin
                checks++;
                if (unit_start !== sel_oh) begin
                    errors++;
                    $display("FAIL %s start_onehot: got %b want %b", name, unit_start, sel_oh);
                end
            end
            if (rsp_valid === 1'b1) begin
                seen = cyc;
            end else begin
                case (noise)
                    1:       dn = 3'($urandom);
                    2:       dn = 3'b111;
                    default: dn = 3'b000;
                endcase
                dn = dn & ~sel_oh;
                if ((cyc == 1 && $urandom_range(0, 1) == 1) || (cyc > 1 && cyc - 1 == d))
                    dn = dn | sel_oh;
                unit_done = dn;
                @(posedge clk); #1;
                cyc++;
            end
        end

        checks++;
        if (seen != e_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d (0 = never)", name, seen, e_lat);
        end
        checks++;
        if (starts != e_starts) begin
            errors++;
            $display("FAIL %s start_count: got %0d want %0d", name, starts, e_starts);
        end
        checks++;
        if (rsp_result !== e_res || rsp_flags !== e_flg || rsp_err !== e_err) begin
            errors++;
            $display("FAIL %s response: got %h/%b/%b want %h/%b/%b", name,
                     rsp_result, rsp_flags, rsp_err, e_res, e_flg, e_err);
        end
        checks++;
        if (busy !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s resp_status: got busy=%b ready=%b want 1/0", name, busy, req_ready);
        end

        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            if (req_in_hold) begin
                req_valid = 1'b1;
                req_op = 2'($urandom);
                req_a = W'($urandom);
                req_b = W'($urandom);
            end
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== e_res || rsp_flags !== e_flg ||
                rsp_err !== e_err || req_ready !== 1'b0 || unit_a !== a || unit_b !== b) begin
                errors++;
                $display("FAIL %s hold%0d: got v=%b r=%h f=%b e=%b rdy=%b a=%h want 1/%h/%b/%b/0/%h",
                         name, h, rsp_valid, rsp_result, rsp_flags, rsp_err, req_ready,
                         unit_a, e_res, e_flg, e_err, a);
            end
        end

        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        unit_done = 3'b000;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s release: got v=%b rdy=%b busy=%b want 0/1/0", name,
                     rsp_valid, req_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || unit_start !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy=%b busy=%b v=%b start=%b want 1/0/0/000",
                     req_ready, busy, rsp_valid, unit_start);
        end
        checks++;
        if (rsp_result !== '0 || rsp_flags !== 4'b0 || rsp_err !== 1'b0 ||
            unit_a !== '0 || unit_b !== '0) begin
            errors++;
            $display("FAIL reset_data: got r=%h f=%b e=%b a=%h b=%h want zeros",
                     rsp_result, rsp_flags, rsp_err, unit_a, unit_b);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mod();
        unit_res = {16'hFFFF, 16'h1234, 16'h5678};
        unit_flg = {4'b0100, 4'b1111, 4'b1010};
        run_op("mod_neg7_3", 2'b10, 16'hFFF9, 16'h0003, 17, 0, 0, 1'b0);
        checks++;
        if (rsp_result !== 16'hFFFF || rsp_flags !== 4'b0100) begin
            errors++;
            $display("FAIL mod_literal: got %h/%b want ffff/0100", rsp_result, rsp_flags);
        end
    endtask

    task automatic test_timeout();
        unit_res = {W'($urandom), W'($urandom), W'($urandom)};
        unit_flg = 12'($urandom);
        run_op("div_timeout", 2'b01, 16'h1000, 16'h0000, 1000, 0, 2, 1'b0);
    endtask

    task automatic test_back_to_back();
        unit_res = {W'($urandom), W'($urandom), W'($urandom)};
        unit_flg = 12'($urandom);
        run_op("b2b_mul", 2'b00, 16'h0012, 16'h0034, 3, 0, 0, 1'b0);
        run_op("b2b_div", 2'b01, 16'h0100, 16'h0010, 1, 0, 0, 1'b0);
    endtask

    task automatic test_reserved();
        unit_res = {W'($urandom), W'($urandom), W'($urandom)};
        unit_flg = 12'($urandom);
        run_op("reserved", 2'b11, 16'hABCD, 16'h1234, 1, 2, 1, 1'b0);
    endtask

    task automatic test_other_done();
        unit_res = {W'($urandom), W'($urandom), W'($urandom)};
        unit_flg = 12'($urandom);
        run_op("mod_div_done_high", 2'b10, 16'h0055, 16'h0007, 20, 2, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        unit_res = {W'($urandom), W'($urandom), W'($urandom)};
        unit_flg = 12'($urandom);
        run_op("backpressure", 2'b00, 16'h7FFF, 16'h0002, 6, 1, 10, 1'b1);
    endtask

    task automatic test_boundary();
        unit_res = {W'($urandom), W'($urandom), W'($urandom)};
        unit_flg = 12'($urandom);
        run_op("done_at_limit", 2'b01, 16'h0009, 16'h0003, T, 0, 0, 1'b0);
        run_op("done_after_limit", 2'b10, 16'h0009, 16'h0003, T + 1, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_op = 2'b00; req_a = 16'h1111; req_b = 16'h2222;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (unit_start !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_launch: got start=%b busy=%b want 000/0", unit_start, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        req_valid = 1'b1; req_op = 2'b01; req_a = 16'h3333; req_b = 16'h4444;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (unit_start !== 3'b000 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
            req_ready !== 1'b1 || unit_a !== '0) begin
            errors++;
            $display("FAIL reset_in_wait: got start=%b v=%b busy=%b rdy=%b a=%h want 000/0/0/1/0",
                     unit_start, rsp_valid, busy, req_ready, unit_a);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        unit_res = {W'($urandom), W'($urandom), W'($urandom)};
        unit_flg = 12'($urandom);
        run_op("mul_after_reset", 2'b00, 16'h0021, 16'h0003, 4, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            unit_res = {W'($urandom), W'($urandom), W'($urandom)};
            unit_flg = 12'($urandom);
            run_op($sformatf("rand%0d", i), 2'($urandom), W'($urandom), W'($urandom),
                   int'($urandom_range(0, T + 3)), 1, int'($urandom_range(0, 3)),
                   $urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_op = 2'b00;
        req_a = '0;
        req_b = '0;
        unit_done = 3'b000;
        unit_res = '0;
        unit_flg = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_mod();
        test_timeout();
        test_back_to_back();
        test_reserved();
        test_other_done();
        test_backpressure();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
